// File: rtl/fp_align_stage.sv
// rtl/fp_align_stage.sv - half-precision add/sub operand alignment front end
// Unpacks, orders by magnitude and registers operands for the barrel shifter.
module fp_align_stage #(
  parameter  int ExpWidth   = 5,
  parameter  int ManWidth   = 10,
  parameter  int MaxShift   = 11,
  localparam int SigWidth   = ManWidth + 1,
  localparam int ShiftWidth = $clog2(MaxShift + 1),
  localparam int OpWidth    = ExpWidth + ManWidth + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [OpWidth-1:0]    op_a_i,
  input  logic [OpWidth-1:0]    op_b_i,
  input  logic                  sub_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [SigWidth-1:0]   big_sig_o,
  output logic [SigWidth-1:0]   small_sig_o,
  output logic [ShiftWidth-1:0] shift_amount_o,
  output logic [ExpWidth-1:0]   exp_o,
  output logic                  sign_o,
  output logic                  eff_sub_o,
  output logic                  far_o,
  output logic                  special_o
);

  localparam logic [ExpWidth-1:0] MaxShiftExp = ExpWidth'(MaxShift);

  logic                  sign_a, sign_b;
  logic [ExpWidth-1:0]   exp_a, exp_b;
  logic [ExpWidth-1:0]   eexp_a, eexp_b;
  logic [SigWidth-1:0]   sig_a, sig_b;
  logic                  b_big;
  logic [ExpWidth-1:0]   diff;
  logic                  far;
  logic [ShiftWidth-1:0] shift;
  logic                  load;

  // Subnormals take the minimum normal exponent so they align without a special path.
  always_comb begin
    sign_a = op_a_i[OpWidth-1];
    sign_b = op_b_i[OpWidth-1] ^ sub_i;
    exp_a  = op_a_i[OpWidth-2 -: ExpWidth];
    exp_b  = op_b_i[OpWidth-2 -: ExpWidth];
    eexp_a = (exp_a == '0) ? ExpWidth'(1) : exp_a;
    eexp_b = (exp_b == '0) ? ExpWidth'(1) : exp_b;
    sig_a  = {exp_a != '0, op_a_i[ManWidth-1:0]};
    sig_b  = {exp_b != '0, op_b_i[ManWidth-1:0]};
    b_big  = (eexp_b > eexp_a) || ((eexp_b == eexp_a) && (sig_b > sig_a));
    diff   = b_big ? (eexp_b - eexp_a) : (eexp_a - eexp_b);
    far    = diff > MaxShiftExp;
    shift  = far ? ShiftWidth'(MaxShift) : ShiftWidth'(diff);
  end

  assign ready_o = !valid_o || ready_i;
  assign load    = valid_i && ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o        <= 1'b0;
      big_sig_o      <= '0;
      small_sig_o    <= '0;
      shift_amount_o <= '0;
      exp_o          <= '0;
      sign_o         <= 1'b0;
      eff_sub_o      <= 1'b0;
      far_o          <= 1'b0;
      special_o      <= 1'b0;
    end else begin
      if (load) begin
        valid_o        <= 1'b1;
        big_sig_o      <= b_big ? sig_b : sig_a;
        small_sig_o    <= b_big ? sig_a : sig_b;
        shift_amount_o <= shift;
        exp_o          <= b_big ? eexp_b : eexp_a;
        sign_o         <= b_big ? sign_b : sign_a;
        eff_sub_o      <= sign_a ^ sign_b;
        far_o          <= far;
        special_o      <= (&exp_a) || (&exp_b);
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_align_stage.sv
// tb/tb_fp_align_stage.sv - randomized self-checking bench for fp_align_stage
// Reference model works on integer magnitudes and an expected-output register.
module tb_fp_align_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] op_a_i;
  logic [15:0] op_b_i;
  logic        sub_i;
  logic        valid_o;
  logic        ready_i;
  logic [10:0] big_sig_o;
  logic [10:0] small_sig_o;
  logic [3:0]  shift_amount_o;
  logic [4:0]  exp_o;
  logic        sign_o;
  logic        eff_sub_o;
  logic        far_o;
  logic        special_o;

  int checks = 0;
  int errors = 0;

  logic        model_valid = 1'b0;
  logic [34:0] model_out   = '0;

  fp_align_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .sub_i(sub_i), .valid_o(valid_o),
    .ready_i(ready_i), .big_sig_o(big_sig_o), .small_sig_o(small_sig_o),
    .shift_amount_o(shift_amount_o), .exp_o(exp_o), .sign_o(sign_o),
    .eff_sub_o(eff_sub_o), .far_o(far_o), .special_o(special_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [34:0] dut_pack();
    return {big_sig_o, small_sig_o, shift_amount_o, exp_o, sign_o, eff_sub_o, far_o, special_o};
  endfunction

  // Magnitude = effective exponent * 2048 + significand orders operands directly.
  function automatic logic [34:0] ref_align(logic [15:0] a, logic [15:0] b, logic s);
    int ea, eb, eea, eeb, siga, sigb, sa, sb, bigsig, smallsig, ebig, esmall, sbig, diff, sh;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    eea = (ea == 0) ? 1 : ea;
    eeb = (eb == 0) ? 1 : eb;
    siga = ((ea != 0) ? 1024 : 0) + int'(a[9:0]);
    sigb = ((eb != 0) ? 1024 : 0) + int'(b[9:0]);
    sa = int'(a[15]);
    sb = int'(b[15] ^ s);
    if (eeb * 2048 + sigb > eea * 2048 + siga) begin
      bigsig = sigb; smallsig = siga; ebig = eeb; esmall = eea; sbig = sb;
    end else begin
      bigsig = siga; smallsig = sigb; ebig = eea; esmall = eeb; sbig = sa;
    end
    diff = ebig - esmall;
    sh = (diff > 11) ? 11 : diff;
    return {11'(bigsig), 11'(smallsig), 4'(sh), 5'(ebig), 1'(sbig), 1'(sa != sb),
            1'(diff > 11), 1'(ea == 31 || eb == 31)};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled at the following falling edge.
  task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic r);
    valid_i = v; op_a_i = a; op_b_i = b; sub_i = s; ready_i = r;
    #1;
    check("ready_o", 64'(ready_o), 64'(!model_valid || r));
    @(posedge clk_i);
    if (v && (!model_valid || r)) begin
      model_out   = ref_align(a, b, s);
      model_valid = 1'b1;
    end else if (r) begin
      model_valid = 1'b0;
    end
    @(negedge clk_i);
    check("valid_o", 64'(valid_o), 64'(model_valid));
    if (model_valid) check("data", 64'(dut_pack()), 64'(model_out));
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 5))
      0: v[14:10] = 5'd0;
      1: v[14:10] = 5'd31;
      2: v[14:10] = 5'($urandom_range(13, 17));
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; op_a_i = '0; op_b_i = '0; sub_i = 1'b0; ready_i = 1'b0;
    #1;
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_data", 64'(dut_pack()), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd1);
    @(negedge clk_i);
    rst_i = 1'b0;

    cycle(1'b1, 16'h4000, 16'h3C00, 1'b0, 1'b1);
    check("tp1_big", 64'(big_sig_o), 64'h400);
    check("tp1_shift", 64'(shift_amount_o), 64'd1);
    check("tp1_exp", 64'(exp_o), 64'd16);
    cycle(1'b1, 16'h3C01, 16'h3C02, 1'b1, 1'b1);
    check("tp2_sign", 64'(sign_o), 64'd1);
    cycle(1'b1, 16'h7800, 16'h3C00, 1'b0, 1'b1);
    check("tp3_shift", 64'(shift_amount_o), 64'd11);
    check("tp3_far", 64'(far_o), 64'd1);
    cycle(1'b1, 16'h7C00, 16'h3C00, 1'b0, 1'b1);
    check("tp3_special", 64'(special_o), 64'd1);
    cycle(1'b1, 16'h0001, 16'h0400, 1'b0, 1'b1);
    check("tp4_exp", 64'(exp_o), 64'd1);
    cycle(1'b1, 16'h3C00, 16'hBC00, 1'b1, 1'b1);
    cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);

    // Backpressure: hold the result while inputs wander, then pass-through reload.
    cycle(1'b1, 16'h4500, 16'h3800, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_op(), rand_op(), 1'b1, 1'b0);
    cycle(1'b1, 16'h5000, 16'h4C00, 1'b1, 1'b1);
    cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);

    // Back-to-back stream interrupted by an asynchronous reset.
    for (int i = 0; i < 4; i++) cycle(1'b1, rand_op(), rand_op(), 1'($urandom), 1'b1);
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    model_valid = 1'b0;
    #1;
    check("async_rst_valid", 64'(valid_o), 64'd0);
    check("async_rst_data", 64'(dut_pack()), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    cycle(1'b1, 16'h4000, 16'h3C00, 1'b1, 1'b1);

    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), rand_op(), rand_op(), 1'($urandom),
            1'($urandom_range(0, 3) != 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_align_stage.md
Name: fp_align_stage

Overview:
- Operand-alignment front end of the half-precision FP add/sub datapath. It sits directly upstream of barrel_shifter.
- Unpacks both operands and applies the effective operation (add/sub) to the sign of B.
- Orders the operands by magnitude and computes the saturated exponent difference.
- Registers the larger significand, the smaller significand and the shift amount, which drive barrel_shifter.data_i and barrel_shifter.shift_amount_i. One-entry valid/ready pipeline register.

Parameters:
ExpWidth, 5, exponent field width
ManWidth, 10, stored mantissa width; significand SigWidth = ManWidth+1 (hidden bit included)
MaxShift, 11, saturation limit for the shift amount; must match barrel_shifter MaxShift

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
valid_i  input  1  input operands valid
ready_o  output  1  stage can accept input this cycle
op_a_i  input  ExpWidth+ManWidth+1  operand A {sign, exp, man}
op_b_i  input  ExpWidth+ManWidth+1  operand B {sign, exp, man}
sub_i  input  1  1 = A-B, 0 = A+B
valid_o  output  1  output register holds a result
ready_i  input  1  downstream accepts the result
big_sig_o  output  SigWidth  significand of the larger-magnitude operand
small_sig_o  output  SigWidth  significand of the smaller operand, to barrel_shifter data_i
shift_amount_o  output  $clog2(MaxShift+1)  min(exp difference, MaxShift), to barrel_shifter
exp_o  output  ExpWidth  effective exponent of the larger operand
sign_o  output  1  effective sign of the larger operand (tentative result sign)
eff_sub_o  output  1  effective operation is subtraction
far_o  output  1  exponent difference > MaxShift; small operand contributes sticky only
special_o  output  1  either operand exponent is all ones (Inf/NaN)

Behaviour:
- Reset: all outputs and internal registers are cleared to 0 immediately when rst_i is asserted, without waiting for a clock edge. While rst_i is high, valid_o = 0 and ready_o reflects only valid_o = 0. An in-flight result is discarded when reset is asserted mid-operation.
- Handshake:
  - ready_o = !valid_o || ready_i (combinational).
  - Transfer in occurs when valid_i && ready_o. Transfer out occurs when valid_o && ready_i.
  - Latency is 1 cycle. Throughput is 1 result/cycle with ready_i held high.
  - Transfer in: the register loads at the next edge and valid_o = 1.
  - Transfer out with no transfer in: valid_o = 0.
  - Simultaneous transfer in and out: the register reloads and valid_o stays 1.
  - While valid_o && !ready_i, every output is held stable, and op_*_i changes are ignored.
- Unpack, per operand:
  - hidden bit = (exp != 0).
  - effective exponent = (exp == 0) ? 1 : exp, so subnormals align with the minimum normal.
  - sig = {hidden, man}.
- Effective signs: sA = sign_a; sB = sign_b ^ sub_i. eff_sub_o = sA ^ sB.
- Ordering: B is "big" iff eexp_b > eexp_a, or (eexp_b == eexp_a and sig_b > sig_a). On exact magnitude equality A is big. The big operand supplies big_sig_o, exp_o and sign_o.
- diff = eexp_big - eexp_small, always >= 0 and computed at ExpWidth width.
- shift_amount_o = (diff > MaxShift) ? MaxShift : diff. far_o = (diff > MaxShift).
- special_o = (exp_a == all ones) || (exp_b == all ones). All other outputs are computed normally; a later stage resolves specials.
- No state machine beyond the valid register. All arithmetic is unsigned with no wrap-around possible.

Test Plan:
- A=0x4000 (2.0), B=0x3C00 (1.0), sub_i=0, ready_i=1 -> next cycle: valid_o=1, big_sig_o=0x400, small_sig_o=0x400, shift_amount_o=1, exp_o=16, sign_o=0, eff_sub_o=0, far_o=0.
- A=0x3C01, B=0x3C02, sub_i=1 (equal exponents) -> B is big: big_sig_o=0x402, small_sig_o=0x401, shift_amount_o=0, sign_o=1, eff_sub_o=1.
- A=0x7800 (exp 30), B=0x3C00 (exp 15) -> shift_amount_o=11, far_o=1, exp_o=30. Second case: A=0x7C00 -> special_o=1.
- A=0x0001 (subnormal), B=0x0400 (min normal) -> big_sig_o=0x400, small_sig_o=0x001, shift_amount_o=0, exp_o=1.
- Backpressure:
  - Accept one input, then hold ready_i=0 for 3 cycles while changing op_a_i -> valid_o=1, ready_o=0, outputs unchanged.
  - Raise ready_i with valid_i=1 -> output and input transfer in the same cycle, and valid_o stays 1.
- Stream 4 back-to-back inputs with ready_i=1, then assert rst_i asynchronously mid-stream -> valid_o and all outputs drop to 0 before the next edge. The first transfer after reset release produces correct results.
